// File: rtl/vga_game_pkg.sv
// Shared types and constants for the VGA game-flow sequencer.
package vga_game_pkg;

    localparam int unsigned StateW = 4;
    localparam int unsigned BcdW   = 4;
    localparam logic [BcdW-1:0] BcdMax = 4'd9;

    typedef enum logic [StateW-1:0] {
        StIdle      = 4'd0,
        StCountdown = 4'd1,
        StPlay      = 4'd2,
        StRoundEnd  = 4'd3,
        StGameOver  = 4'd4
    } state_e;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with clear, load, increment and decrement.
// Saturates at 99 when incrementing and at 00 when decrementing.
module bcd2_counter
    import vga_game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [2*BcdW-1:0] load_val,
    input  logic              inc,
    input  logic              dec,
    output logic [BcdW-1:0]   tens,
    output logic [BcdW-1:0]   ones
);

    logic [BcdW-1:0] tens_q, tens_d;
    logic [BcdW-1:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (load) begin
            tens_d = load_val[2*BcdW-1:BcdW];
            ones_d = load_val[BcdW-1:0];
        end else if (inc) begin
            if (!(tens_q == BcdMax && ones_q == BcdMax)) begin
                if (ones_q == BcdMax) begin
                    ones_d = '0;
                    tens_d = tens_q + 1'b1;
                end else begin
                    ones_d = ones_q + 1'b1;
                end
            end
        end else if (dec) begin
            if (!(tens_q == '0 && ones_q == '0)) begin
                if (ones_q == '0) begin
                    ones_d = BcdMax;
                    tens_d = tens_q - 1'b1;
                end else begin
                    ones_d = ones_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/vga_game_seq.sv
// Game-flow sequencer feeding the VGA pixel generator. Every displayed value
// is committed only on a frame tick (vsync falling edge), so frames never tear.
module vga_game_seq
    import vga_game_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC   = 60,
    parameter int unsigned CNT_START        = 3,
    parameter int unsigned WIN_SCORE        = 9,
    parameter int unsigned ROUND_END_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start,
    input  logic       point0,
    input  logic       point1,
    output logic [3:0] state,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] cnt0,
    output logic [3:0] cnt1
);

    localparam int unsigned FsecW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int unsigned RcntW = (ROUND_END_FRAMES > 1) ? $clog2(ROUND_END_FRAMES) : 1;
    localparam logic [FsecW-1:0]  FsecLast   = FsecW'(FRAMES_PER_SEC - 1);
    localparam logic [RcntW-1:0]  RcntLast   = RcntW'(ROUND_END_FRAMES - 1);
    localparam logic [3:0]        WinScore   = 4'(WIN_SCORE);
    localparam logic [2*BcdW-1:0] CntLoadVal = {BcdW'(0), BcdW'(CNT_START)};

    logic vsync_q, start_q;
    logic tick, start_rise, sec_done;
    logic start_p_q, start_p_d, p0_p_q, p0_p_d, p1_p_q, p1_p_d;

    state_e           state_q, state_d;
    logic [3:0]       score0_q, score0_d, score1_q, score1_d;
    logic [FsecW-1:0] fsec_q, fsec_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic             cnt_clr, cnt_load, cnt_inc, cnt_dec;

    assign tick       = vsync_q & ~vsync;
    assign start_rise = start & ~start_q;
    assign sec_done   = tick && (fsec_q == FsecLast);

    // Every state consumes or discards all flags on a tick; an event landing
    // on the tick cycle itself survives into the next frame.
    always_comb begin
        start_p_d = tick ? start_rise : (start_p_q | start_rise);
        p0_p_d    = tick ? point0     : (p0_p_q | point0);
        p1_p_d    = tick ? point1     : (p1_p_q | point1);
    end

    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        fsec_d   = fsec_q;
        rcnt_d   = rcnt_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (start_p_q) begin
                        state_d  = StCountdown;
                        score0_d = '0;
                        score1_d = '0;
                        cnt_load = 1'b1;
                        fsec_d   = '0;
                    end
                end
                StCountdown: begin
                    fsec_d = sec_done ? '0 : fsec_q + 1'b1;
                    if (sec_done) begin
                        if (cnt0 == 4'd1) begin
                            state_d = StPlay;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                StPlay: begin
                    fsec_d  = sec_done ? '0 : fsec_q + 1'b1;
                    cnt_inc = sec_done;
                    if (p0_p_q || p1_p_q) begin
                        if (p0_p_q) score0_d = (score0_q == WinScore) ? WinScore : score0_q + 4'd1;
                        if (p1_p_q) score1_d = (score1_q == WinScore) ? WinScore : score1_q + 4'd1;
                        if (score0_d == WinScore || score1_d == WinScore) begin
                            state_d = StGameOver;
                        end else begin
                            state_d = StRoundEnd;
                            rcnt_d  = '0;
                        end
                    end
                end
                StRoundEnd: begin
                    if (rcnt_q == RcntLast) begin
                        state_d  = StCountdown;
                        cnt_load = 1'b1;
                        fsec_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                StGameOver: begin
                    if (start_p_q) begin
                        state_d  = StIdle;
                        score0_d = '0;
                        score1_d = '0;
                        cnt_clr  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b1;
            start_q   <= 1'b0;
            start_p_q <= 1'b0;
            p0_p_q    <= 1'b0;
            p1_p_q    <= 1'b0;
            state_q   <= StIdle;
            score0_q  <= '0;
            score1_q  <= '0;
            fsec_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            vsync_q   <= vsync;
            start_q   <= start;
            start_p_q <= start_p_d;
            p0_p_q    <= p0_p_d;
            p1_p_q    <= p1_p_d;
            state_q   <= state_d;
            score0_q  <= score0_d;
            score1_q  <= score1_d;
            fsec_q    <= fsec_d;
            rcnt_q    <= rcnt_d;
        end
    end

    bcd2_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (CntLoadVal),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .tens     (cnt1),
        .ones     (cnt0)
    );

    assign state  = state_q;
    assign score0 = score0_q;
    assign score1 = score1_q;

endmodule

// File: tb/tb_vga_game_seq.sv
// Scoreboard bench for vga_game_seq: expected frame snapshots are queued with
// the stimulus and compared right after the matching frame commit.
module tb_vga_game_seq;

    logic       clk = 1'b0;
    logic       rst, vsync, start, point0, point1;
    logic [3:0] state, score0, score1, cnt0, cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_no = 0;
    event tick_ev, frame_ev;

    typedef struct {
        int         frame;
        string      tag;
        logic [3:0] st, s0, s1, c1, c0;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    vga_game_seq #(
        .FRAMES_PER_SEC   (4),
        .CNT_START        (3),
        .WIN_SCORE        (2),
        .ROUND_END_FRAMES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vsync  (vsync),
        .start  (start),
        .point0 (point0),
        .point1 (point1),
        .state  (state),
        .score0 (score0),
        .score1 (score1),
        .cnt0   (cnt0),
        .cnt1   (cnt1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int f, input string tag, input logic [3:0] st, input logic [3:0] s0,
                        input logic [3:0] s1, input logic [3:0] c1, input logic [3:0] c0);
        exp_t e;
        e.frame = f; e.tag = tag; e.st = st; e.s0 = s0; e.s1 = s1; e.c1 = c1; e.c0 = c0;
        sb.push_back(e);
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [3:0] s0,
                             input logic [3:0] s1, input logic [3:0] c1, input logic [3:0] c0);
        check_val({tag, ".state"},  int'(state),  int'(st));
        check_val({tag, ".score0"}, int'(score0), int'(s0));
        check_val({tag, ".score1"}, int'(score1), int'(s1));
        check_val({tag, ".cnt1"},   int'(cnt1),   int'(c1));
        check_val({tag, ".cnt0"},   int'(cnt0),   int'(c0));
    endtask

    // vsync: 2 clk low every 20 clk; commit edge follows the falling edge.
    initial begin
        exp_t e;
        vsync = 1'b1;
        forever begin
            repeat (18) @(negedge clk);
            vsync = 1'b0;
            -> tick_ev;
            @(posedge clk);
            #1;
            frame_no++;
            while (sb.size() > 0 && sb[0].frame <= frame_no) begin
                e = sb.pop_front();
                check_val({e.tag, ".frame"}, frame_no, e.frame);
                check_all(e.tag, e.st, e.s0, e.s1, e.c1, e.c0);
            end
            -> frame_ev;
            repeat (2) @(negedge clk);
            vsync = 1'b1;
        end
    end

    task automatic wait_frame(input int n);
        do @(frame_ev); while (frame_no < n);
    endtask

    task automatic mid_pulse(input logic s, input logic p0, input logic p1);
        repeat (5) @(negedge clk);
        start = s; point0 = p0; point1 = p1;
        @(negedge clk);
        start = 1'b0; point0 = 1'b0; point1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, m, q, r, s, t, u;
        rst = 1'b1; start = 1'b0; point0 = 1'b0; point1 = 1'b0;
        repeat (30) @(negedge clk);
        check_all("reset", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        rst = 1'b0;

        // Start from idle and walk through countdown into play.
        wait_frame(frame_no + 1);
        k = frame_no;
        mid_pulse(1'b1, 1'b0, 1'b0);
        push(k + 1,  "cd_3a",  4'd1, 4'd0, 4'd0, 4'd0, 4'd3);
        push(k + 4,  "cd_3b",  4'd1, 4'd0, 4'd0, 4'd0, 4'd3);
        push(k + 5,  "cd_2",   4'd1, 4'd0, 4'd0, 4'd0, 4'd2);
        push(k + 9,  "cd_1a",  4'd1, 4'd0, 4'd0, 4'd0, 4'd1);
        push(k + 12, "cd_1b",  4'd1, 4'd0, 4'd0, 4'd0, 4'd1);
        push(k + 13, "play00", 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        push(k + 16, "play00b", 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        push(k + 17, "play01", 4'd2, 4'd0, 4'd0, 4'd0, 4'd1);
        push(k + 52, "play09", 4'd2, 4'd0, 4'd0, 4'd0, 4'd9);
        push(k + 53, "play10", 4'd2, 4'd0, 4'd0, 4'd1, 4'd0);

        // Mid-frame point0, then a start press that ROUND_END must ignore.
        wait_frame(k + 53);
        m = frame_no;
        mid_pulse(1'b0, 1'b1, 1'b0);
        push(m + 1,  "re_a",   4'd3, 4'd1, 4'd0, 4'd1, 4'd0);
        push(m + 2,  "re_b",   4'd3, 4'd1, 4'd0, 4'd1, 4'd0);
        push(m + 3,  "cd2_3",  4'd1, 4'd1, 4'd0, 4'd0, 4'd3);
        push(m + 15, "play2",  4'd2, 4'd1, 4'd0, 4'd0, 4'd0);
        wait_frame(m + 1);
        mid_pulse(1'b1, 1'b0, 1'b0);

        // point1 on the tick cycle is held for the following frame.
        wait_frame(m + 15);
        @(tick_ev);
        q = frame_no + 1;
        point1 = 1'b1;
        push(q,      "tickpt_hold", 4'd2, 4'd1, 4'd0, 4'd0, 4'd0);
        push(q + 1,  "tickpt_next", 4'd3, 4'd1, 4'd1, 4'd0, 4'd0);
        push(q + 3,  "cd3_3",       4'd1, 4'd1, 4'd1, 4'd0, 4'd3);
        push(q + 15, "play3",       4'd2, 4'd1, 4'd1, 4'd0, 4'd0);
        @(negedge clk);
        point1 = 1'b0;

        // Simultaneous points at 1:1 give a draw; further points stay saturated.
        wait_frame(q + 15);
        r = frame_no;
        mid_pulse(1'b0, 1'b1, 1'b1);
        push(r + 1, "draw",      4'd4, 4'd2, 4'd2, 4'd0, 4'd0);
        wait_frame(r + 1);
        mid_pulse(1'b0, 1'b0, 1'b1);
        push(r + 2, "draw_hold", 4'd4, 4'd2, 4'd2, 4'd0, 4'd0);

        // Start from game over returns to idle, then a new game begins.
        wait_frame(r + 2);
        s = frame_no;
        mid_pulse(1'b1, 1'b0, 1'b0);
        push(s + 1, "go_idle", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame(s + 1);
        t = frame_no;
        mid_pulse(1'b1, 1'b0, 1'b0);
        push(t + 1,  "new_cd",   4'd1, 4'd0, 4'd0, 4'd0, 4'd3);
        push(t + 13, "new_play", 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);

        // One-cycle reset in the middle of play.
        wait_frame(t + 13);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("midrst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        u = frame_no;
        push(u + 1, "after_rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame(u + 1);

        check_val("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
